sram_wb_arbiter: RTL

SRAM_WB_ARBITER -- requirements
Module: sram_wb_arbiter

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_rr.sv | 31 +++
 rtl/sram_wb_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM Wishbone arbiter.
package sram_arb_pkg;

  localparam int ADR_W_DEF = 18;
  localparam int DAT_W_DEF = 16;

  // State values double as the one-hot grant seen on gnt_o.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin pick; last_gnt records who was granted most recently.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_sel,
  output logic [1:0] pick
);

  logic last_gnt;

  // Reset to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)      last_gnt <= 1'b1;
    else if (upd) last_gnt <= upd_sel;
  end

  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = last_gnt ? GNT_M0 : GNT_M1;
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Arbitrates host loader (m0) and serial playback (m1) onto one SRAM Wishbone slave.
// Optional ack-wait watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_wb_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit ack-wait counter");
  end

  arb_state_e state, state_nxt;
  logic [1:0] req, pick;
  logic       tmo;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);
  logic [7:0] tmo_cnt;
  logic [1:0] blk;
  logic       cur_stb;

  assign cur_stb = (state == GRANT0) ? m0_stb_i :
                   (state == GRANT1) ? m1_stb_i : 1'b0;
  assign tmo     = (state != IDLE) && (tmo_cnt == TMO_LIM);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_nxt == IDLE || s_ack_i) tmo_cnt <= '0;
    else if (cur_stb)                              tmo_cnt <= tmo_cnt + 8'd1;
  end

  // A timed-out master stays locked out until it releases cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) blk <= '0;
    else begin
      if (tmo && state == GRANT0) blk[0] <= 1'b1;
      else if (!m0_cyc_i)         blk[0] <= 1'b0;
      if (tmo && state == GRANT1) blk[1] <= 1'b1;
      else if (!m1_cyc_i)         blk[1] <= 1'b0;
    end
  end

  assign req = {m1_cyc_i & ~blk[1], m0_cyc_i & ~blk[0]};
`else
  assign tmo = 1'b0;
  assign req = {m1_cyc_i, m0_cyc_i};
`endif

  sram_arb_rr u_rr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (req),
    .upd     ((state == IDLE) && (state_nxt != IDLE)),
    .upd_sel (state_nxt == GRANT1),
    .pick    (pick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Releasing cyc always returns to IDLE, giving a turnaround cycle between grants.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick == GNT_M0)      state_nxt = GRANT0;
        else if (pick == GNT_M1) state_nxt = GRANT1;
      end
      GRANT0:  if (!m0_cyc_i || tmo) state_nxt = IDLE;
      GRANT1:  if (!m1_cyc_i || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_o = state;

  // Routing is combinational so an ack coinciding with cyc release still lands.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (!wb_rst_i) begin
      case (state)
        GRANT0: begin
          s_cyc_o  = m0_cyc_i & ~tmo;
          s_stb_o  = m0_stb_i & ~tmo;
          s_we_o   = m0_we_i;
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i & ~tmo;
          m0_dat_o = s_dat_i;
          m0_err_o = tmo;
        end
        GRANT1: begin
          s_cyc_o  = m1_cyc_i & ~tmo;
          s_stb_o  = m1_stb_i & ~tmo;
          s_we_o   = m1_we_i;
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i & ~tmo;
          m1_dat_o = s_dat_i;
          m1_err_o = tmo;
        end
        default: ;
      endcase
    end
  end

endmodule
